// File: rtl/lcd_pkg.sv
// Shared constants for the character-LCD byte writer: FSM encoding,
// 50 MHz default timing and the 4-bit init nibble sequence.
package lcd_pkg;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_U_SETUP = 4'd1;
    localparam logic [3:0] S_U_PULSE = 4'd2;
    localparam logic [3:0] S_U_HOLD  = 4'd3;
    localparam logic [3:0] S_GAP     = 4'd4;
    localparam logic [3:0] S_L_SETUP = 4'd5;
    localparam logic [3:0] S_L_PULSE = 4'd6;
    localparam logic [3:0] S_L_HOLD  = 4'd7;
    localparam logic [3:0] S_WAIT    = 4'd8;
    localparam logic [3:0] S_I_BOOT  = 4'd9;
    localparam logic [3:0] S_I_WAIT  = 4'd10;
    localparam logic [3:0] S_I_SETUP = 4'd11;
    localparam logic [3:0] S_I_PULSE = 4'd12;
    localparam logic [3:0] S_I_HOLD  = 4'd13;
    localparam logic [3:0] S_I_GAP   = 4'd14;

    localparam int unsigned DEF_SETUP_CYC      = 2;
    localparam int unsigned DEF_PULSE_CYC      = 12;
    localparam int unsigned DEF_HOLD_CYC       = 1;
    localparam int unsigned DEF_NIBBLE_GAP_CYC = 50;
    localparam int unsigned DEF_BYTE_GAP_CYC   = 2000;
    localparam int unsigned DEF_INIT_WAIT_CYC  = 750000;

    // Nibbles sent during power-up init, first nibble in the top bits
    localparam logic [15:0] INIT_SEQ = 16'h3332;

    function automatic int unsigned max_u(input int unsigned a,
                                          input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        logic [15:0] s;
        s = INIT_SEQ << (4 * idx);
        return s[15:12];
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Shared down-counter: load strobe reloads it, done flags a zero count.
// A load value of 0 behaves like 1 so every state lasts one cycle.
module lcd_delay_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (value == '0) ? '0 : value - ONE;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// Byte-to-nibble writer for the 4-bit character LCD interface.
// Define LCD_INIT_EN to run the power-up init sequence after reset.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC      = DEF_SETUP_CYC,
    parameter int unsigned PULSE_CYC      = DEF_PULSE_CYC,
    parameter int unsigned HOLD_CYC       = DEF_HOLD_CYC,
    parameter int unsigned NIBBLE_GAP_CYC = DEF_NIBBLE_GAP_CYC,
    parameter int unsigned BYTE_GAP_CYC   = DEF_BYTE_GAP_CYC
`ifdef LCD_INIT_EN
    ,
    parameter int unsigned INIT_WAIT_CYC  = DEF_INIT_WAIT_CYC
`endif
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic [3:0] oLCD_D,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW
);

    localparam int unsigned MAXB = max_u(
        max_u(max_u(SETUP_CYC, PULSE_CYC), max_u(HOLD_CYC, NIBBLE_GAP_CYC)),
        BYTE_GAP_CYC);
`ifdef LCD_INIT_EN
    localparam int unsigned MAXV = max_u(MAXB, INIT_WAIT_CYC);
`else
    localparam int unsigned MAXV = MAXB;
`endif
    localparam int W = $clog2(MAXV) + 1;

    localparam logic [W-1:0] T_S = W'(SETUP_CYC);
    localparam logic [W-1:0] T_P = W'(PULSE_CYC);
    localparam logic [W-1:0] T_H = W'(HOLD_CYC);
    localparam logic [W-1:0] T_G = W'(NIBBLE_GAP_CYC);
    localparam logic [W-1:0] T_B = W'(BYTE_GAP_CYC);
`ifdef LCD_INIT_EN
    localparam logic [W-1:0] T_I = W'(INIT_WAIT_CYC);
    localparam logic [3:0]   S_RST = S_I_BOOT;
`else
    localparam logic [3:0]   S_RST = S_IDLE;
`endif

    logic [3:0]   state;
    logic [3:0]   nxt;
    logic [3:0]   tgt;
    logic [W-1:0] tval;
    logic         adv;
    logic         done;
    logic [3:0]   d;
    logic [3:0]   lo;
    logic         e;
    logic         rs;
`ifdef LCD_INIT_EN
    logic [1:0]   idx;
`endif

    lcd_delay_timer #(.W(W)) u_tmr (
        .clk   (Clock),
        .rst_n (Reset),
        .load  (adv),
        .value (tval),
        .done  (done)
    );

    // Each state names its successor and the successor's duration;
    // the shared timer is reloaded on every transition.
    always_comb begin
        tgt  = state;
        tval = '0;
        adv  = done;
        case (state)
            S_IDLE: begin
                adv  = iValid;
                tgt  = S_U_SETUP;
                tval = T_S;
            end
            S_U_SETUP: begin tgt = S_U_PULSE; tval = T_P; end
            S_U_PULSE: begin tgt = S_U_HOLD;  tval = T_H; end
            S_U_HOLD:  begin tgt = S_GAP;     tval = T_G; end
            S_GAP:     begin tgt = S_L_SETUP; tval = T_S; end
            S_L_SETUP: begin tgt = S_L_PULSE; tval = T_P; end
            S_L_PULSE: begin tgt = S_L_HOLD;  tval = T_H; end
            S_L_HOLD:  begin tgt = S_WAIT;    tval = T_B; end
            S_WAIT:    begin tgt = S_IDLE;    tval = '0;  end
`ifdef LCD_INIT_EN
            S_I_BOOT: begin
                adv  = 1'b1;
                tgt  = S_I_WAIT;
                tval = T_I;
            end
            S_I_WAIT:  begin tgt = S_I_SETUP; tval = T_S; end
            S_I_SETUP: begin tgt = S_I_PULSE; tval = T_P; end
            S_I_PULSE: begin tgt = S_I_HOLD;  tval = T_H; end
            S_I_HOLD:  begin tgt = S_I_GAP;   tval = T_B; end
            S_I_GAP: begin
                tgt  = (idx == 2'd3) ? S_IDLE : S_I_SETUP;
                tval = T_S;
            end
`endif
            default: begin
                adv = 1'b1;
                tgt = S_IDLE;
            end
        endcase
        nxt = adv ? tgt : state;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_RST;
            e     <= 1'b0;
            rs    <= 1'b0;
            d     <= 4'd0;
            lo    <= 4'd0;
        end else begin
            state <= nxt;
            e     <= (nxt == S_U_PULSE) || (nxt == S_L_PULSE) ||
                     (nxt == S_I_PULSE);
            if (state == S_IDLE && iValid) begin
                d  <= iData[7:4];
                rs <= iRS;
                lo <= iData[3:0];
            end
            if (state == S_GAP && done) begin
                d <= lo;
            end
`ifdef LCD_INIT_EN
            if (adv && tgt == S_I_SETUP) begin
                d  <= init_nibble((state == S_I_WAIT) ? 2'd0 : idx + 2'd1);
                rs <= 1'b0;
            end
`endif
        end
    end

`ifdef LCD_INIT_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            idx <= 2'd0;
        end else if (state == S_I_GAP && done) begin
            idx <= idx + 2'd1;
        end
    end
`endif

    assign oReady  = (state == S_IDLE);
    assign oLCD_D  = d;
    assign oLCD_E  = e;
    assign oLCD_RS = rs;
    assign oLCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Scoreboard bench for lcd_byte_writer with S=1 P=2 H=1 G=3 B=5.
// Expected {RS,D} per E pulse is queued by stimulus, popped by a monitor.
module tb_lcd_byte_writer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iRS = 1'b0;
    logic       iValid = 1'b0;
    logic       oReady;
    logic [3:0] oLCD_D;
    logic       oLCD_E;
    logic       oLCD_RS;
    logic       oLCD_RW;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [4:0] sb[$];

    lcd_byte_writer #(
        .SETUP_CYC      (1),
        .PULSE_CYC      (2),
        .HOLD_CYC       (1),
        .NIBBLE_GAP_CYC (3),
        .BYTE_GAP_CYC   (5)
`ifdef LCD_INIT_EN
        ,
        .INIT_WAIT_CYC  (10)
`endif
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .iData   (iData),
        .iRS     (iRS),
        .iValid  (iValid),
        .oReady  (oReady),
        .oLCD_D  (oLCD_D),
        .oLCD_E  (oLCD_E),
        .oLCD_RS (oLCD_RS),
        .oLCD_RW (oLCD_RW)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop on each E rising edge, check pulse width and stability
    logic       prev_e = 1'b0;
    logic [4:0] cap = 5'd0;
    int         width = 0;

    always @(negedge Clock) begin
        if (!Reset) begin
            prev_e = 1'b0;
            width  = 0;
        end else begin
            if (oLCD_E && !prev_e) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_pulse: got rs=%0d d=%0h expected none",
                             oLCD_RS, oLCD_D);
                end else begin
                    check("nibble", int'({oLCD_RS, oLCD_D}), int'(sb.pop_front()));
                end
                cap   = {oLCD_RS, oLCD_D};
                width = 1;
            end else if (oLCD_E) begin
                width++;
                check("stable_in_pulse", int'({oLCD_RS, oLCD_D}), int'(cap));
            end else if (prev_e) begin
                check("pulse_width", width, 2);
            end
            prev_e = oLCD_E;
        end
    end

    task automatic issue(input logic [7:0] b, input logic r,
                         input logic hold, output int acc);
        @(negedge Clock);
        check("ready_before_issue", int'(oReady), 1);
        iData  = b;
        iRS    = r;
        iValid = 1'b1;
        @(posedge Clock);
        #1;
        acc    = cyc;
        iValid = hold;
    endtask

    task automatic wait_ready(input int acc, input string name,
                              input int exp_lat);
        int n;
        n = 0;
        @(negedge Clock);
        while (!oReady && n < 200) begin
            @(negedge Clock);
            n++;
        end
        check(name, cyc - acc, exp_lat);
    endtask

    task automatic wait_idle_bounded(input string name);
        int n;
        n = 0;
        @(negedge Clock);
        while (!oReady && n < 300) begin
            @(negedge Clock);
            n++;
        end
        check(name, int'(oReady), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1;
        int acc2;
        int n;

        // Reset values
        @(negedge Clock);
        check("rst_e", int'(oLCD_E), 0);
        check("rst_d", int'(oLCD_D), 0);
        check("rst_rs", int'(oLCD_RS), 0);
        check("rst_rw", int'(oLCD_RW), 0);
`ifdef LCD_INIT_EN
        check("rst_ready_init", int'(oReady), 0);
        sb.push_back(5'h03);
        sb.push_back(5'h03);
        sb.push_back(5'h03);
        sb.push_back(5'h02);
`else
        check("rst_ready", int'(oReady), 1);
`endif
        #1 Reset = 1'b1;
        @(negedge Clock);
        check("rel_e", int'(oLCD_E), 0);
        check("rel_d", int'(oLCD_D), 0);
        check("rel_rw", int'(oLCD_RW), 0);
`ifdef LCD_INIT_EN
        check("init_ready_low", int'(oReady), 0);
        repeat (20) @(negedge Clock);
        check("init_ready_mid", int'(oReady), 0);
        wait_idle_bounded("init_done_ready");
        check("init_sb_empty", sb.size(), 0);
`else
        check("rel_ready", int'(oReady), 1);
`endif

        // Single data byte 0xA5
        sb.push_back(5'h1A);
        sb.push_back(5'h15);
        issue(8'hA5, 1'b1, 1'b0, acc1);
        wait_ready(acc1, "lat_a5", 16);
        check("sb_empty_a5", sb.size(), 0);

        // Back-to-back 0x28 then 0x0C with iValid held
        sb.push_back(5'h02);
        sb.push_back(5'h08);
        sb.push_back(5'h00);
        sb.push_back(5'h0C);
        issue(8'h28, 1'b0, 1'b1, acc1);
        iData = 8'h0C;
        n = 0;
        @(negedge Clock);
        while (!oReady && n < 100) begin
            @(negedge Clock);
            n++;
        end
        @(posedge Clock);
        #1;
        acc2   = cyc;
        iValid = 1'b0;
        check("b2b_accept_gap", acc2 - acc1, 17);
        wait_ready(acc2, "lat_0c", 16);
        check("sb_empty_b2b", sb.size(), 0);

        // Busy-time iValid pulses and data changes are ignored
        sb.push_back(5'h03);
        sb.push_back(5'h0C);
        issue(8'h3C, 1'b0, 1'b0, acc1);
        repeat (4) begin
            @(negedge Clock);
            iData  = 8'hFF;
            iRS    = 1'b1;
            iValid = 1'b1;
            @(negedge Clock);
            iValid = 1'b0;
        end
        wait_ready(acc1, "lat_busy", 16);
        repeat (25) @(negedge Clock);
        check("sb_empty_busy", sb.size(), 0);
        check("ready_after_busy", int'(oReady), 1);

        // Reset during the upper-nibble pulse
        sb.push_back(5'h19);
        issue(8'h96, 1'b1, 1'b0, acc1);
        n = 0;
        @(negedge Clock);
        while (!oLCD_E && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check("saw_upper_pulse", int'(oLCD_E), 1);
        #1 Reset = 1'b0;
        #1;
        check("async_e", int'(oLCD_E), 0);
        check("async_d", int'(oLCD_D), 0);
        check("async_rs", int'(oLCD_RS), 0);
`ifdef LCD_INIT_EN
        check("async_ready", int'(oReady), 0);
        sb.push_back(5'h03);
        sb.push_back(5'h03);
        sb.push_back(5'h03);
        sb.push_back(5'h02);
`else
        check("async_ready", int'(oReady), 1);
`endif
        @(negedge Clock);
        #1 Reset = 1'b1;
`ifdef LCD_INIT_EN
        wait_idle_bounded("reinit_ready");
`endif
        repeat (30) @(negedge Clock);
        check("post_rst_ready", int'(oReady), 1);
        check("post_rst_sb_empty", sb.size(), 0);

        repeat (5) @(negedge Clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_byte_writer.md
Name: lcd_byte_writer

Overview:
- Downstream consumer of the MiniAlu result byte: takes 8-bit data/command bytes and drives the Spartan-3E character LCD over its 4-bit interface.
- Serialises each byte as upper nibble then lower nibble, applying LCD setup, enable-pulse, hold and inter-transfer timing in clock cycles.
- Sits between the ALU/sequencer (valid/ready producer) and the board LCD pins.

Parameters:
- SETUP_CYC, 2, cycles D/RS are stable with E low before the E pulse (40 ns at 50 MHz).
- PULSE_CYC, 12, cycles E is held high (≥230 ns).
- HOLD_CYC, 1, cycles D/RS are held with E low after the pulse.
- NIBBLE_GAP_CYC, 50, idle cycles between upper and lower nibble (1 µs).
- BYTE_GAP_CYC, 2000, idle cycles after the lower nibble before the next accept (40 µs).
- INIT_WAIT_CYC, 750000, power-up wait before the first init nibble (15 ms); used only with LCD_INIT_EN.

Ports:
- Clock, input, 1, system clock, rising edge.
- Reset, input, 1, asynchronous, active-low reset.
- iData, input, 8, byte to write.
- iRS, input, 1, register select: 0 = command, 1 = data.
- iValid, input, 1, iData/iRS valid.
- oReady, output, 1, block can accept a byte.
- oLCD_D, output, 4, LCD data nibble (SF_D[11:8]).
- oLCD_E, output, 1, LCD enable.
- oLCD_RS, output, 1, LCD register select.
- oLCD_RW, output, 1, LCD read/write; tied 0 (write only).

Behaviour:
- Reset (Reset = 0, asynchronous): state = IDLE, oLCD_E = 0, oLCD_RS = 0, oLCD_D = 0, oLCD_RW = 0, counter = 0, oReady = 1 (0 when LCD_INIT_EN is defined).
- Handshake:
  - A transfer is accepted on the rising edge where iValid & oReady are both 1. iData and iRS are latched at that edge.
  - oReady goes 0 on the next cycle and stays 0 until WAIT completes.
  - iValid while oReady = 0 is ignored. Inputs need not stay stable after accept.
- FSM states, each with a down-counter loaded with its parameter:
  - IDLE → U_SETUP on accept.
  - U_SETUP: D = byte[7:4], RS = latched RS, E = 0, for SETUP_CYC cycles.
  - U_PULSE: E = 1, for PULSE_CYC cycles.
  - U_HOLD: E = 0, D/RS held, for HOLD_CYC cycles.
  - GAP: NIBBLE_GAP_CYC cycles.
  - L_SETUP, L_PULSE, L_HOLD: same as the U_ states, with D = byte[3:0].
  - WAIT: BYTE_GAP_CYC cycles, then → IDLE with oReady = 1.
- Latency: the accept edge to oReady = 1 is exactly 2·(S+P+H)+G+B cycles, where S = SETUP_CYC, P = PULSE_CYC, H = HOLD_CYC, G = NIBBLE_GAP_CYC, B = BYTE_GAP_CYC. With defaults this is 2080.
- Boundary conditions:
  - A parameter value of 0 is treated as 1; each state lasts at least one cycle.
  - Counter width is clog2 of the largest parameter + 1. The counter never wraps; it reloads on every state entry.
  - oLCD_D and oLCD_RS change only while E = 0. E is never high in setup, hold, gap or wait states.
  - Back-to-back bytes: if iValid is held high, the next accept occurs on the first cycle oReady = 1 (one IDLE cycle).
  - Reset mid-transfer: all outputs go to reset values immediately, including E dropping low; any partial byte is discarded.
  - oLCD_D holds its last nibble during GAP/WAIT/IDLE. It returns to 0 only on reset.

Optional Feature:
- LCD_INIT_EN defined:
  - After reset, FSM runs INIT: wait INIT_WAIT_CYC cycles.
  - Then send nibbles 0x3, 0x3, 0x3, 0x2 with RS = 0. Each nibble uses the setup/pulse/hold timing, followed by a BYTE_GAP_CYC wait.
  - Then → IDLE with oReady = 1. oReady stays 0 throughout INIT.
- LCD_INIT_EN undefined: INIT states and INIT_WAIT_CYC logic are absent; oReady = 1 directly after reset.

Decomposition:
- Package lcd_pkg holds:
  - FSM state encoding constants (IDLE, U_SETUP … WAIT, INIT_*).
  - Default timing constants for 50 MHz.
  - Init nibble sequence constant {3,3,3,2}.
- Sub-module lcd_delay_timer: load value, load strobe, done flag. Instantiated once and shared by all states.

Test Plan:
All scenarios use S=1, P=2, H=1, G=3, B=5 (total 16 cycles).
1. Reset release, LCD_INIT_EN undefined → oReady = 1, E = 0, D = 0, RW = 0 on the first edge.
2. Accept iData = 0xA5, iRS = 1 →
   - E pulse of 2 cycles with D = 0xA, RS = 1.
   - 3-cycle gap.
   - E pulse of 2 cycles with D = 0x5.
   - oReady = 1 exactly 16 cycles after accept.
3. iValid held high with 0x28 then 0x0C → second accept occurs 17 cycles after the first. E nibble sequence is 2, 8, 0, C.
4. Change iData and pulse iValid while busy → no effect on the in-flight nibbles; nothing is queued.
5. Assert Reset during U_PULSE (E = 1) → E = 0 asynchronously, before the next clock edge. After release, oReady = 1 and no lower nibble is emitted.
6. LCD_INIT_EN defined, INIT_WAIT_CYC = 10 →
   - oReady = 0 during init.
   - E pulses carry D = 3, 3, 3, 2 with RS = 0.
   - oReady = 1 afterwards.
